// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: occupancy state encoding.
// PS_TWO is only reachable when the skid register is built in.
package pipe_pkg;

    typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register, load enable and sync clear, async reset to 0; 1-cycle latency.
// No handshake: the owning stage decides when to load or clear.
module pipe_data_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage, 1-cycle latency, stall holds data; flush kills all entries.
// PIPE_STAGE_SKID_EN adds a skid register and a registered in_ready; otherwise in_ready is combinational.
import pipe_pkg::*;

module pipe_stage #(
    parameter int WIDTH          = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    pipe_state_t      state_q, state_d;
    logic             in_xfer, out_xfer;
    logic             main_load, data_clr;
    logic [WIDTH-1:0] main_d;

    assign out_valid = (state_q != PS_EMPTY);
    assign out_xfer  = out_valid & out_ready & ~stall;
    assign in_xfer   = in_valid & in_ready;
    assign data_clr  = flush & CLEAR_ON_FLUSH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_data_reg #(.WIDTH(WIDTH)) u_main (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (data_clr),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (out_data)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_load;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_data;
        case (state_q)
            PS_EMPTY: begin
                if (in_xfer) begin
                    state_d   = PS_ONE;
                    main_load = 1'b1;
                end
            end
            PS_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (out_xfer) begin
                    state_d = PS_EMPTY;
                end else if (in_xfer) begin
                    state_d   = PS_TWO;
                    skid_load = 1'b1;
                end
            end
            PS_TWO: begin
                // in_ready is low here, so the only move is skid -> main
                if (out_xfer) begin
                    state_d   = PS_ONE;
                    main_load = 1'b1;
                    main_d    = skid_q;
                end
            end
            default: state_d = PS_EMPTY;
        endcase
        if (flush) begin
            state_d   = PS_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != PS_TWO);
        end
    end

    assign in_ready = in_ready_q;

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (data_clr),
        .load_i (skid_load),
        .d_i    (in_data),
        .q_o    (skid_q)
    );
`else
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_d    = in_data;
        case (state_q)
            PS_EMPTY: begin
                if (in_xfer) begin
                    state_d   = PS_ONE;
                    main_load = 1'b1;
                end
            end
            PS_ONE: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                end else if (out_xfer) begin
                    state_d = PS_EMPTY;
                end
            end
            default: state_d = PS_EMPTY;
        endcase
        if (flush) begin
            state_d   = PS_EMPTY;
            main_load = 1'b0;
        end
    end

    // Accept only when the single register is empty or draining this cycle
    assign in_ready = ~out_valid | (out_ready & ~stall);
`endif

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and a downstream stall that actually holds data. It replaces the flat enable-less stage register between core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The optional skid buffer gives full throughput with a registered `in_ready`, which breaks the ready path between stages.

## Interface
- `WIDTH`, default 32: payload width in bits.
- `CLEAR_ON_FLUSH`, default 1: 1 zeroes the data registers on flush; 0 clears only the valid bits.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset. Single clock domain.
- `flush` input 1: synchronous kill of every held entry.
- `stall` input 1: downstream hold; qualifies `out_ready`.
- `in_valid` input 1: upstream payload valid.
- `in_ready` output 1: stage can accept this cycle.
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: payload presented downstream.
- `out_ready` input 1: downstream accepts.
- `out_data` output WIDTH: presented payload.

## Operation
- Input transfer: `in_valid & in_ready`.
- Output transfer: `out_valid & out_ready & ~stall`.
- Storage is a main register (drives `out_*`) plus, with skid, one skid register.
- State is {EMPTY, ONE, TWO}. TWO exists only with skid.
- EMPTY, input transfer: go to ONE, main <= in_data.
- ONE, input and output transfer: stay in ONE, main <= in_data.
- ONE, output only: go to EMPTY.
- ONE, input only: with skid, skid <= in_data and go to TWO. Without skid this case cannot occur, because `in_ready` is 0.
- TWO, output transfer: main <= skid, go to ONE. No input is possible because `in_ready` is 0.
- TWO, no output transfer: hold.
- Ordering is strictly FIFO. No payload is duplicated or dropped except by flush.
- `flush` has priority over every transition. Next state is EMPTY.
- Handshakes in the flush cycle complete normally. An output transfer counts as delivered; accepted input is discarded.
- `stall=1` is exactly equivalent to `out_ready=0`. Payload and valid are held stable.
- `out_data` while `out_valid=0`: 0 after reset, or after flush when `CLEAR_ON_FLUSH=1`; otherwise the last value.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, skid data 0, state EMPTY.
- `in_ready` reset value: 1 with skid. Without skid it is combinational; its value during reset is 1.
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 transfer per cycle in steady state.
- Skid `in_ready` is a register: equals (next state != TWO).
- No-skid `in_ready = ~out_valid | (out_ready & ~stall)`. This is a combinational path from `out_ready`/`stall`.
- `out_valid` and `out_data` are registered in both modes; no input-to-output combinational path.
- `rst` asserted mid-operation: all state clears immediately (asynchronous). The first acceptance is possible on the first rising edge after deassertion.
- Flush cycle N: `out_valid=0` from N+1; `in_ready=1` from N+1.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: skid register present, states {EMPTY, ONE, TWO}, registered `in_ready`.
- `PIPE_STAGE_SKID_EN` undefined: single register, states {EMPTY, ONE}, combinational `in_ready`. Skid logic is absent from the netlist.
- Port list is identical in both builds.

## Structure
- Shared package `pipe_pkg`: `typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t`.
- One sub-module `pipe_data_reg`: WIDTH-bit register with load enable, synchronous clear, asynchronous reset to 0.
- Instantiate `pipe_data_reg` for the main register and, under the macro, for the skid register.

## Test plan
- Reset, then stream 0x1..0x8 with `out_ready=1`: outputs 0x1..0x8 on consecutive cycles, 1-cycle latency, `in_ready` stays 1.
- Skid build: accept 0xA then 0xB while `stall=1` → `in_ready` falls the cycle after 0xB. Release stall → 0xA, then 0xB, then `in_ready=1`.
- No-skid build, same stimulus: `in_ready=0` in the cycle 0xB is offered. 0xB is accepted only in the cycle 0xA leaves.
- State TWO (0xC main, 0xD skid), pulse `flush` with `in_valid=1` and `in_data=0xE` → next cycle `out_valid=0`, `out_data=0` (`CLEAR_ON_FLUSH=1`), `in_ready=1`. 0xE is never output.
- Assert `rst` asynchronously between edges while in state ONE with 0x55 → `out_valid=0` and `out_data=0` immediately. Normal acceptance resumes after deassertion.
